// File: rtl/crc_error_monitor.sv
// Synchronizes and debounces the configuration-CRC error level, counts qualified
// events and holds a level interrupt until the host acknowledges it.
module crc_error_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int HOLDOFF     = 16,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 crc_error_in,
    input  logic                 enable,
    input  logic                 ack,
    input  logic                 clear_count,
    output logic                 irq,
    output logic [CNT_WIDTH-1:0] error_count,
    output logic                 overflow,
    output logic [2:0]           state
);

    // state   | meaning
    // IDLE    | monitor disabled
    // ARMED   | waiting for synchronized error level
    // QUALIFY | error seen, counting consecutive high samples
    // ALERT   | qualified event, irq asserted until ack
    // HOLDOFF | post-ack dead time
    // REARM   | waiting for error level to drop before re-arming
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        QUALIFY = 3'd2,
        ALERT   = 3'd3,
        HOLD    = 3'd4,
        REARM   = 3'd5
    } state_t;

    localparam int QW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF - 1);

    state_t                 cur_state, nxt_state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [QW-1:0]          qcnt, qcnt_nxt;
    logic [HW-1:0]          hcnt, hcnt_nxt;
    logic                   enter_alert;

    assign s     = sync[SYNC_STAGES-1];
    assign state = cur_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], crc_error_in};
        end
    end

    always_comb begin
        nxt_state = cur_state;
        qcnt_nxt  = qcnt;
        hcnt_nxt  = hcnt;
        if (!enable) begin
            nxt_state = IDLE;
            qcnt_nxt  = '0;
            hcnt_nxt  = '0;
        end else begin
            case (cur_state)
                IDLE: begin
                    nxt_state = ARMED;
                end
                ARMED: begin
                    if (s) begin
                        if (DEBOUNCE == 1) begin
                            nxt_state = ALERT;
                        end else begin
                            nxt_state = QUALIFY;
                            qcnt_nxt  = QW'(1);
                        end
                    end
                end
                QUALIFY: begin
                    if (!s) begin
                        nxt_state = ARMED;
                        qcnt_nxt  = '0;
                    end else if (qcnt == Q_LAST) begin
                        nxt_state = ALERT;
                        qcnt_nxt  = '0;
                    end else begin
                        qcnt_nxt = qcnt + QW'(1);
                    end
                end
                ALERT: begin
                    if (ack) begin
                        nxt_state = HOLD;
                        hcnt_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (hcnt == H_LAST) begin
                        nxt_state = REARM;
                        hcnt_nxt  = '0;
                    end else begin
                        hcnt_nxt = hcnt + HW'(1);
                    end
                end
                REARM: begin
                    // A level that never drops is a single event; wait it out here.
                    if (!s) begin
                        nxt_state = ARMED;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                    qcnt_nxt  = '0;
                    hcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign enter_alert = (cur_state != ALERT) && (nxt_state == ALERT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            qcnt      <= '0;
            hcnt      <= '0;
            irq       <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            qcnt      <= qcnt_nxt;
            hcnt      <= hcnt_nxt;
            irq       <= (nxt_state == ALERT);
        end
    end

    // A clear coinciding with a new event leaves that event counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_count <= '0;
            overflow    <= 1'b0;
        end else if (clear_count) begin
            error_count <= enter_alert ? CNT_WIDTH'(1) : '0;
            overflow    <= 1'b0;
        end else if (enter_alert) begin
            if (&error_count) begin
                overflow <= 1'b1;
            end else begin
                error_count <= error_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_crc_error_monitor.sv
// Directed-vector bench for crc_error_monitor with a 2-bit event counter so
// saturation is reachable in a handful of events.
module tb_crc_error_monitor;

    logic       clock;
    logic       reset_n;
    logic       crc_error_in;
    logic       enable;
    logic       ack;
    logic       clear_count;
    logic       irq;
    logic [1:0] error_count;
    logic       overflow;
    logic [2:0] state;

    int vectors;
    int miscompares;

    crc_error_monitor #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .HOLDOFF    (16),
        .CNT_WIDTH  (2)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .crc_error_in(crc_error_in),
        .enable      (enable),
        .ack         (ack),
        .clear_count (clear_count),
        .irq         (irq),
        .error_count (error_count),
        .overflow    (overflow),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One full qualified event from ARMED, acked with the input dropped, back to ARMED.
    task automatic run_event(input string tag, input logic [1:0] exp_cnt, input logic exp_ovf);
        crc_error_in = 1'b1;
        tick(6);
        chk({tag, "_irq"}, 32'(irq), 32'd1);
        chk({tag, "_cnt"}, 32'(error_count), 32'(exp_cnt));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        ack          = 1'b1;
        crc_error_in = 1'b0;
        tick(1);
        ack = 1'b0;
        tick(17);
        chk({tag, "_armed"}, 32'(state), 32'd1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        crc_error_in = 1'b0;
        enable       = 1'b0;
        ack          = 1'b0;
        clear_count  = 1'b0;
        #3;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_cnt", 32'(error_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        chk("idle_no_enable", 32'(state), 32'd0);
        enable = 1'b1;
        tick(1);
        chk("armed", 32'(state), 32'd1);

        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_ignored", 32'(state), 32'd1);

        // glitch: three high synced samples, one short of qualifying
        crc_error_in = 1'b1;
        tick(3);
        crc_error_in = 1'b0;
        tick(2);
        chk("glitch_qualify", 32'(state), 32'd2);
        tick(1);
        chk("glitch_armed", 32'(state), 32'd1);
        chk("glitch_irq", 32'(irq), 32'd0);
        chk("glitch_cnt", 32'(error_count), 32'd0);
        tick(3);

        // latency: irq rises on the sixth edge after the input change
        crc_error_in = 1'b1;
        tick(5);
        chk("lat_irq_early", 32'(irq), 32'd0);
        tick(1);
        chk("lat_irq", 32'(irq), 32'd1);
        chk("lat_cnt", 32'(error_count), 32'd1);
        chk("lat_state", 32'(state), 32'd3);

        // ack with input held: holdoff, rearm, no recount
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("ack_irq", 32'(irq), 32'd0);
        chk("ack_state", 32'(state), 32'd4);
        tick(15);
        chk("holdoff_last", 32'(state), 32'd4);
        tick(1);
        chk("rearm", 32'(state), 32'd5);
        tick(50);
        chk("rearm_held", 32'(state), 32'd5);
        chk("rearm_cnt", 32'(error_count), 32'd1);
        chk("rearm_irq", 32'(irq), 32'd0);
        crc_error_in = 1'b0;
        tick(2);
        chk("rearm_wait", 32'(state), 32'd5);
        tick(1);
        chk("rearm_armed", 32'(state), 32'd1);

        // saturation and clear
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr_cnt", 32'(error_count), 32'd0);
        run_event("ev1", 2'd1, 1'b0);
        run_event("ev2", 2'd2, 1'b0);
        run_event("ev3", 2'd3, 1'b0);
        run_event("ev4", 2'd3, 1'b1);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr2_cnt", 32'(error_count), 32'd0);
        chk("clr2_ovf", 32'(overflow), 32'd0);

        // clear on the alert-entry edge keeps the new event
        crc_error_in = 1'b1;
        tick(5);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr_alert_irq", 32'(irq), 32'd1);
        chk("clr_alert_cnt", 32'(error_count), 32'd1);
        chk("clr_alert_ovf", 32'(overflow), 32'd0);

        // disable in ALERT, with ack on the same edge
        enable       = 1'b0;
        ack          = 1'b1;
        crc_error_in = 1'b0;
        tick(1);
        ack = 1'b0;
        chk("dis_alert_state", 32'(state), 32'd0);
        chk("dis_alert_irq", 32'(irq), 32'd0);
        chk("dis_alert_cnt", 32'(error_count), 32'd1);
        enable = 1'b1;
        tick(1);
        chk("reen_armed", 32'(state), 32'd1);
        tick(3);

        // disable in QUALIFY
        crc_error_in = 1'b1;
        tick(4);
        chk("q_state", 32'(state), 32'd2);
        enable       = 1'b0;
        crc_error_in = 1'b0;
        tick(1);
        chk("dis_q_state", 32'(state), 32'd0);
        chk("dis_q_cnt", 32'(error_count), 32'd1);
        enable = 1'b1;
        tick(1);
        chk("reen2_armed", 32'(state), 32'd1);
        tick(3);
        chk("reen2_stable", 32'(state), 32'd1);
        chk("reen2_irq", 32'(irq), 32'd0);

        // async reset between edges while in ALERT
        crc_error_in = 1'b1;
        tick(6);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        chk("pre_rst_cnt", 32'(error_count), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_cnt", 32'(error_count), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
